topk_insert_sorter: RTL and testbench
=====================================

TOPK_INSERT_SORTER -- requirements
Module: topk_insert_sorter

Interface
REQ-001 SHALL have parameter K, default 8: number of retained entries; legal range 2..64.
REQ-002 SHALL have parameter W, default 16: key (distance) width in bits.
REQ-003 SHALL have parameter TYPE_W, default 3: class-label width in bits.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1: an input element is presented.
REQ-007 SHALL have port in_ready, output, 1: the block accepts an element this cycle.
REQ-008 SHALL have port in_last, input, 1: the presented element closes the frame.
REQ-009 SHALL have port ascending, input, 1: 1 keeps the K smallest keys, 0 keeps the K largest.
REQ-010 SHALL have port in_key, input, W: distance key.
REQ-011 SHALL have port in_type, input, TYPE_W: label paired with in_key.
REQ-012 SHALL have port out_valid, output, 1: the result frame is presented.
REQ-013 SHALL have port out_ready, input, 1: the consumer accepts the result.
REQ-014 SHALL have port out_keys, output, W*K: slot i at bits [W*i +: W]; slot 0 is best.
REQ-015 SHALL have port out_types, output, TYPE_W*K: labels aligned to out_keys.
REQ-016 SHALL have port out_count, output, clog2(K+1): number of valid slots, saturating at K.

Function
REQ-017 SHALL implement a two-state FSM: COLLECT (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-018 SHALL accept an element when in_valid && in_ready, and insert it in the same cycle, one element per cycle with no bubbles.
REQ-019 SHALL latch ascending on the first accepted element of each frame and ignore ascending for the rest of that frame.
REQ-020 SHALL keep slots ordered best-first (non-decreasing when ascending, non-increasing otherwise).
REQ-021 SHALL insert stably: a new key equal to a stored key lands after it.
REQ-022 SHALL discard the worst entry when full and a better key arrives; it SHALL discard the new key when it is not strictly better than slot K-1.
REQ-023 SHALL fill empty slots with key all-ones (ascending) or all-zeros (descending) and type 0.
REQ-024 SHALL move to HOLD on the clock edge that accepts in_last, so out_valid asserts one cycle after the last accept.
REQ-025 SHALL hold out_keys, out_types and out_count stable while out_valid && !out_ready.
REQ-026 SHALL, on out_valid && out_ready, clear all slots and out_count and return to COLLECT, so in_ready is 1 in the next cycle.
REQ-027 SHALL treat in_valid, in_last, in_key and in_type as don't-care in HOLD.
REQ-028 SHALL handle a single-element frame (in_last on the first element) as out_count=1.

Reset
REQ-029 SHALL, while rst is high, force state COLLECT, out_valid=0, in_ready=1 and out_count=0, and set every slot to all-ones key with type 0.
REQ-030 SHALL abandon any partial frame or held result when rst asserts mid-operation; no output is produced for it.

Structure
REQ-031 SHALL take its FSM state encoding and default K/W/TYPE_W values from shared package knn_pkg.
REQ-032 SHALL build its storage from K instances of sub-module topk_cell: one slot register, comparator against the input, and a shift-from-neighbour mux.

Verification (K=4, W=16, TYPE_W=3)
REQ-033 SHALL cover ascending frame 9/t1, 3/t2, 7/t3, 1/t4, 5/t5(last) -> keys 1,3,5,7; types 4,2,5,3; out_count=4.
REQ-034 SHALL cover descending frame 9, 3, 7, 1, 5(last) -> keys 9,7,5,3.
REQ-035 SHALL cover ascending frame 4/t1, 4/t2(last) -> keys 4,4,FFFF,FFFF; types 1,2,0,0; out_count=2.
REQ-036 SHALL cover out_ready held low 5 cycles -> outputs stable and in_ready=0; when out_ready rises -> in_ready=1 the next cycle.
REQ-037 SHALL cover rst pulsed after 2 accepted elements, then frame 8(last) -> keys 8,FFFF,FFFF,FFFF; out_count=1.
REQ-038 SHALL cover back-to-back frames with in_valid held high -> exactly one idle cycle per frame boundary, and no element lost or mixed across frames.

Source files
------------

// File: rtl/knn_pkg.sv
// Shared types and default sizes for the k-nearest-neighbour datapath.
package knn_pkg;

  localparam int K_DEF      = 8;
  localparam int W_DEF      = 16;
  localparam int TYPE_W_DEF = 3;

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_HOLD    = 1'b1
  } sorter_state_e;

endpackage

// File: rtl/topk_cell.sv
// One slot of the top-K list: stored entry, compare against the
// incoming key, and a mux that either loads the input or the upper neighbour.
module topk_cell
  import knn_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int TYPE_W = TYPE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              ins_i,
  input  logic              asc_i,
  input  logic [W-1:0]      in_key_i,
  input  logic [TYPE_W-1:0] in_type_i,
  input  logic              prev_better_i,
  input  logic              prev_vld_i,
  input  logic [W-1:0]      prev_key_i,
  input  logic [TYPE_W-1:0] prev_type_i,
  output logic              better_o,
  output logic              vld_o,
  output logic [W-1:0]      key_o,
  output logic [TYPE_W-1:0] type_o
);

  logic              vld_q, vld_d;
  logic [W-1:0]      key_q, key_d;
  logic [TYPE_W-1:0] type_q, type_d;

  // Strict compare keeps insertion stable: equal keys land behind.
  always_comb begin
    better_o = 1'b1;
    if (vld_q) begin
      better_o = asc_i ? (in_key_i < key_q)
                       : (in_key_i > key_q);
    end
  end

  always_comb begin
    vld_d  = vld_q;
    key_d  = key_q;
    type_d = type_q;
    if (clr_i) begin
      vld_d  = 1'b0;
      key_d  = '1;
      type_d = '0;
    end else if (ins_i && better_o) begin
      if (prev_better_i) begin
        vld_d  = prev_vld_i;
        key_d  = prev_key_i;
        type_d = prev_type_i;
      end else begin
        vld_d  = 1'b1;
        key_d  = in_key_i;
        type_d = in_type_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      key_q  <= '1;
      type_q <= '0;
    end else begin
      vld_q  <= vld_d;
      key_q  <= key_d;
      type_q <= type_d;
    end
  end

  assign vld_o  = vld_q;
  assign key_o  = key_q;
  assign type_o = type_q;

endmodule

// File: rtl/topk_insert_sorter.sv
// Streaming top-K selector: keeps the K best keys of a frame, sorted
// best-first, and holds the result until the consumer takes it.
module topk_insert_sorter
  import knn_pkg::*;
#(
  parameter int K      = K_DEF,
  parameter int W      = W_DEF,
  parameter int TYPE_W = TYPE_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic                   ascending,
  input  logic [W-1:0]           in_key,
  input  logic [TYPE_W-1:0]      in_type,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W*K-1:0]         out_keys,
  output logic [TYPE_W*K-1:0]    out_types,
  output logic [$clog2(K+1)-1:0] out_count
);

  localparam int CW = $clog2(K+1);

  sorter_state_e state_q, state_d;
  logic          asc_q, asc_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic accept;
  logic release_w;
  logic first;
  logic asc_eff;

  logic              better [K];
  logic              vld    [K];
  logic [W-1:0]      key    [K];
  logic [TYPE_W-1:0] typ    [K];
  logic              p_bet  [K];
  logic              p_vld  [K];
  logic [W-1:0]      p_key  [K];
  logic [TYPE_W-1:0] p_typ  [K];

  assign accept    = in_valid && in_ready;
  assign release_w = out_valid && out_ready;
  assign first     = (cnt_q == '0);
  // Direction is taken live on the first element, latched afterwards.
  assign asc_eff   = first ? ascending : asc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_COLLECT: if (accept && in_last) state_d = S_HOLD;
      S_HOLD:    if (out_ready)         state_d = S_COLLECT;
      default:   state_d = S_COLLECT;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      S_COLLECT: in_ready  = 1'b1;
      S_HOLD:    out_valid = 1'b1;
      default:   in_ready  = 1'b1;
    endcase
  end

  always_comb begin
    asc_d = asc_q;
    cnt_d = cnt_q;
    if (release_w) begin
      asc_d = 1'b1;
      cnt_d = '0;
    end else if (accept) begin
      if (first) asc_d = ascending;
      if (cnt_q != CW'(K)) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asc_q <= 1'b1;
      cnt_q <= '0;
    end else begin
      asc_q <= asc_d;
      cnt_q <= cnt_d;
    end
  end

  for (genvar g = 0; g < K; g++) begin : g_slot
    if (g == 0) begin : g_head
      assign p_bet[g] = 1'b0;
      assign p_vld[g] = 1'b0;
      assign p_key[g] = in_key;
      assign p_typ[g] = in_type;
    end else begin : g_link
      assign p_bet[g] = better[g-1];
      assign p_vld[g] = vld[g-1];
      assign p_key[g] = key[g-1];
      assign p_typ[g] = typ[g-1];
    end

    topk_cell #(
      .W      (W),
      .TYPE_W (TYPE_W)
    ) u_cell (
      .clk           (clk),
      .rst           (rst),
      .clr_i         (release_w),
      .ins_i         (accept),
      .asc_i         (asc_eff),
      .in_key_i      (in_key),
      .in_type_i     (in_type),
      .prev_better_i (p_bet[g]),
      .prev_vld_i    (p_vld[g]),
      .prev_key_i    (p_key[g]),
      .prev_type_i   (p_typ[g]),
      .better_o      (better[g]),
      .vld_o         (vld[g]),
      .key_o         (key[g]),
      .type_o        (typ[g])
    );

    // Empty slots read as the worst possible key for the frame direction.
    assign out_keys[W*g +: W] =
      vld[g] ? key[g] : (asc_q ? {W{1'b1}} : {W{1'b0}});
    assign out_types[TYPE_W*g +: TYPE_W] = typ[g];
  end

  assign out_count = cnt_q;

endmodule

// File: tb/tb_topk_insert_sorter.sv
// Directed bench for topk_insert_sorter with K=4, W=16, TYPE_W=3.
module tb_topk_insert_sorter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic        ascending;
  logic [15:0] in_key;
  logic [2:0]  in_type;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_keys;
  logic [11:0] out_types;
  logic [2:0]  out_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  topk_insert_sorter #(.K(4), .W(16), .TYPE_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .ascending (ascending),
    .in_key    (in_key),
    .in_type   (in_type),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_keys  (out_keys),
    .out_types (out_types),
    .out_count (out_count)
  );

  // Presents one element at posedge+1 and returns at the next posedge+1.
  task automatic send(input logic [15:0] k, input logic [2:0] t,
                      input logic l, input logic a);
    in_valid  = 1'b1;
    in_key    = k;
    in_type   = t;
    in_last   = l;
    ascending = a;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs got rdy=%b vld=%b exp rdy=1 vld=0",
               in_ready, out_valid);
    end
    checks++;
    if (out_count !== 3'd0) begin
      failures++;
      $display("FAIL reset_count got=%0d exp=0", out_count);
    end
    checks++;
    if (out_keys !== {4{16'hFFFF}} || out_types !== 12'd0) begin
      failures++;
      $display("FAIL reset_slots got keys=%h types=%h exp keys=%h types=0",
               out_keys, out_types, {4{16'hFFFF}});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_ascending();
    send(16'd9, 3'd1, 1'b0, 1'b1);
    send(16'd3, 3'd2, 1'b0, 1'b1);
    send(16'd7, 3'd3, 1'b0, 1'b1);
    send(16'd1, 3'd4, 1'b0, 1'b1);
    send(16'd5, 3'd5, 1'b1, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL asc_hold got vld=%b rdy=%b exp vld=1 rdy=0",
               out_valid, in_ready);
    end
    checks++;
    if (out_keys !== {16'd7, 16'd5, 16'd3, 16'd1}) begin
      failures++;
      $display("FAIL asc_keys got=%h exp=%h", out_keys,
               {16'd7, 16'd5, 16'd3, 16'd1});
    end
    checks++;
    if (out_types !== {3'd3, 3'd5, 3'd2, 3'd4}) begin
      failures++;
      $display("FAIL asc_types got=%h exp=%h", out_types,
               {3'd3, 3'd5, 3'd2, 3'd4});
    end
    checks++;
    if (out_count !== 3'd4) begin
      failures++;
      $display("FAIL asc_count got=%0d exp=4", out_count);
    end
    release_out();
  endtask

  task automatic test_descending();
    send(16'd9, 3'd1, 1'b0, 1'b0);
    send(16'd3, 3'd2, 1'b0, 1'b0);
    send(16'd7, 3'd3, 1'b0, 1'b0);
    send(16'd1, 3'd4, 1'b0, 1'b0);
    send(16'd5, 3'd5, 1'b1, 1'b0);
    checks++;
    if (out_keys !== {16'd3, 16'd5, 16'd7, 16'd9}) begin
      failures++;
      $display("FAIL desc_keys got=%h exp=%h", out_keys,
               {16'd3, 16'd5, 16'd7, 16'd9});
    end
    checks++;
    if (out_types !== {3'd2, 3'd5, 3'd3, 3'd1}) begin
      failures++;
      $display("FAIL desc_types got=%h exp=%h", out_types,
               {3'd2, 3'd5, 3'd3, 3'd1});
    end
    release_out();
    send(16'd5, 3'd1, 1'b1, 1'b0);
    checks++;
    if (out_keys !== {16'd0, 16'd0, 16'd0, 16'd5} || out_count !== 3'd1) begin
      failures++;
      $display("FAIL desc_fill got keys=%h cnt=%0d exp keys=%h cnt=1",
               out_keys, out_count, {16'd0, 16'd0, 16'd0, 16'd5});
    end
    release_out();
  endtask

  task automatic test_ties();
    send(16'd4, 3'd1, 1'b0, 1'b1);
    send(16'd4, 3'd2, 1'b1, 1'b1);
    checks++;
    if (out_keys !== {16'hFFFF, 16'hFFFF, 16'd4, 16'd4}) begin
      failures++;
      $display("FAIL tie_keys got=%h exp=%h", out_keys,
               {16'hFFFF, 16'hFFFF, 16'd4, 16'd4});
    end
    checks++;
    if (out_types !== {3'd0, 3'd0, 3'd2, 3'd1} || out_count !== 3'd2) begin
      failures++;
      $display("FAIL tie_types got types=%h cnt=%0d exp types=%h cnt=2",
               out_types, out_count, {3'd0, 3'd0, 3'd2, 3'd1});
    end
    release_out();
  endtask

  task automatic test_boundaries();
    // Full list: key equal to the worst slot must be dropped.
    send(16'd1, 3'd1, 1'b0, 1'b1);
    send(16'd2, 3'd2, 1'b0, 1'b1);
    send(16'd3, 3'd3, 1'b0, 1'b1);
    send(16'd4, 3'd4, 1'b0, 1'b1);
    send(16'd4, 3'd7, 1'b1, 1'b1);
    checks++;
    if (out_keys !== {16'd4, 16'd3, 16'd2, 16'd1} ||
        out_types !== {3'd4, 3'd3, 3'd2, 3'd1}) begin
      failures++;
      $display("FAIL full_equal got keys=%h types=%h exp keys=%h types=%h",
               out_keys, out_types, {16'd4, 16'd3, 16'd2, 16'd1},
               {3'd4, 3'd3, 3'd2, 3'd1});
    end
    checks++;
    if (out_count !== 3'd4) begin
      failures++;
      $display("FAIL count_sat got=%0d exp=4", out_count);
    end
    release_out();
    // All-ones key still occupies an empty slot.
    send(16'hFFFF, 3'd3, 1'b1, 1'b1);
    checks++;
    if (out_count !== 3'd1 || out_types !== {3'd0, 3'd0, 3'd0, 3'd3}) begin
      failures++;
      $display("FAIL max_key got cnt=%0d types=%h exp cnt=1 types=%h",
               out_count, out_types, {3'd0, 3'd0, 3'd0, 3'd3});
    end
    release_out();
    // Direction changes after the first element are ignored.
    send(16'd6, 3'd1, 1'b0, 1'b1);
    send(16'd2, 3'd2, 1'b0, 1'b0);
    send(16'd8, 3'd3, 1'b1, 1'b0);
    checks++;
    if (out_keys !== {16'hFFFF, 16'd8, 16'd6, 16'd2}) begin
      failures++;
      $display("FAIL asc_latch got=%h exp=%h", out_keys,
               {16'hFFFF, 16'd8, 16'd6, 16'd2});
    end
    release_out();
  endtask

  task automatic test_hold();
    logic [63:0] exp_k;
    exp_k = {16'hFFFF, 16'hFFFF, 16'd2, 16'd1};
    send(16'd2, 3'd1, 1'b0, 1'b1);
    send(16'd1, 3'd2, 1'b1, 1'b1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_key    = 16'd0;
    in_type   = 3'd7;
    in_last   = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_keys !== exp_k || out_types !== {3'd0, 3'd0, 3'd1, 3'd2} ||
          out_count !== 3'd2) begin
        failures++;
        $display("FAIL hold_stable cyc=%0d got keys=%h types=%h cnt=%0d",
                 c, out_keys, out_types, out_count);
      end
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL hold_hs cyc=%0d got rdy=%b vld=%b exp rdy=0 vld=1",
                 c, in_ready, out_valid);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    release_out();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_count !== 3'd0) begin
      failures++;
      $display("FAIL hold_release got rdy=%b vld=%b cnt=%0d exp 1 0 0",
               in_ready, out_valid, out_count);
    end
  endtask

  task automatic test_reset_mid();
    send(16'd5, 3'd1, 1'b0, 1'b1);
    send(16'd6, 3'd2, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_count !== 3'd0 || in_ready !== 1'b1 ||
        out_keys !== {4{16'hFFFF}}) begin
      failures++;
      $display("FAIL mid_reset got cnt=%0d rdy=%b keys=%h exp 0 1 all-ones",
               out_count, in_ready, out_keys);
    end
    #2 rst = 1'b0;
    @(posedge clk); #1;
    send(16'd8, 3'd3, 1'b1, 1'b1);
    checks++;
    if (out_keys !== {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd8} ||
        out_count !== 3'd1) begin
      failures++;
      $display("FAIL after_reset got keys=%h cnt=%0d exp keys=%h cnt=1",
               out_keys, out_count, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd8});
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    logic [15:0] ek [6];
    logic [2:0]  et [6];
    logic        el [6];
    logic        ea [6];
    logic [63:0] rk [3];
    logic [11:0] rt [3];
    logic [63:0] xk [3];
    logic [11:0] xt [3];
    int idx, res, idle, iters;
    ek = '{16'd3, 16'd1, 16'd2, 16'd7, 16'd5, 16'd9};
    et = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    el = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    ea = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    xk = '{{16'hFFFF, 16'd3, 16'd2, 16'd1},
           {16'd0, 16'd0, 16'd5, 16'd7},
           {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd9}};
    xt = '{{3'd0, 3'd1, 3'd3, 3'd2},
           {3'd0, 3'd0, 3'd5, 3'd4},
           {3'd0, 3'd0, 3'd0, 3'd6}};
    idx = 0; res = 0; idle = 0; iters = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    while (res < 3 && iters < 40) begin
      iters++;
      if (out_valid === 1'b1) begin
        rk[res] = out_keys;
        rt[res] = out_types;
        res++;
        idle++;
      end else if (idx < 6) begin
        in_key    = ek[idx];
        in_type   = et[idx];
        in_last   = el[idx];
        ascending = ea[idx];
        idx++;
      end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (res != 3) begin
      failures++;
      $display("FAIL b2b_timeout got frames=%0d exp=3", res);
    end else begin
      for (int f = 0; f < 3; f++) begin
        checks++;
        if (rk[f] !== xk[f] || rt[f] !== xt[f]) begin
          failures++;
          $display("FAIL b2b_frame%0d got keys=%h types=%h exp keys=%h types=%h",
                   f, rk[f], rt[f], xk[f], xt[f]);
        end
      end
      checks++;
      if (idle != 3 || iters != 9) begin
        failures++;
        $display("FAIL b2b_idle got idle=%0d cycles=%0d exp idle=3 cycles=9",
                 idle, iters);
      end
    end
  endtask

  initial begin
    in_valid  = 1'b0;
    in_last   = 1'b0;
    ascending = 1'b1;
    in_key    = '0;
    in_type   = '0;
    out_ready = 1'b0;
    test_reset();
    test_ascending();
    test_descending();
    test_ties();
    test_boundaries();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
